// File: rtl/vram_port_arbiter_pkg.sv
// Shared types for the video RAM port arbiter: default widths, read-return
// owner tags and the issue state encoding.
package vram_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  // Who a read in flight belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  // Operation placed on the memory port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VGA_RD = 2'd1,
    ST_CPU_RD = 2'd2,
    ST_CPU_WR = 2'd3
  } issue_t;

  // Owner tag a memory operation produces; writes return nothing.
  function automatic owner_t owner_of(input issue_t st);
    owner_t own;
    case (st)
      ST_VGA_RD: own = OWN_VGA;
      ST_CPU_RD: own = OWN_CPU;
      default:   own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/vram_port_arbiter_rd_tag_pipe.sv
// Owner tag shift register. A tag enters together with the grant decision and
// emerges DEPTH cycles later, in the cycle the matching word sits on mem_rdata.
module vram_rd_tag_pipe
  import vram_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_tag,
  output logic [1:0] o_tag
);

  logic [1:0] r_stage [DEPTH];

  // Shift owner tags toward the output; reset discards everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= OWN_NONE;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port video RAM arbiter between the VGA fetch path and the CPU window.
// The grant is decided combinationally each cycle (vga_gnt reflects it) and
// registered onto mem_*. The memory presents read data RD_LAT-1 cycles after
// the cycle mem_en is high; the word is registered here, so vga_valid/cpu_ack
// land RD_LAT cycles after mem_en.
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starve_flag
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // CPU holding register
  logic              r_pending;
  logic              r_p_we;
  logic [ADDR_W-1:0] r_p_addr;
  logic [DATA_W-1:0] r_p_wdata;
  logic [3:0]        r_starve_cnt;
  logic              r_starve_flag;

  // Memory port and return path
  issue_t            r_state;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_vga_data;
  logic              r_vga_valid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_ack;

  issue_t            w_next_state;
  logic              w_override;
  logic              w_cpu_issue;
  logic              w_vga_issue;
  logic              w_accept;
  logic [3:0]        w_starve_nxt;
  logic [1:0]        w_tag_in;
  logic [1:0]        w_tag_out;

  // Grant decision: starvation override, then display fetch, then CPU.
  always_comb begin
    w_next_state = ST_IDLE;
    w_override   = 1'b0;
    if (r_pending && (r_starve_cnt == STARVE_LIM)) begin
      w_override   = 1'b1;
      w_next_state = r_p_we ? ST_CPU_WR : ST_CPU_RD;
    end else if (vga_req) begin
      w_next_state = ST_VGA_RD;
    end else if (r_pending) begin
      w_next_state = r_p_we ? ST_CPU_WR : ST_CPU_RD;
    end else begin
      w_next_state = ST_IDLE;
    end
  end

  assign w_cpu_issue = (w_next_state == ST_CPU_RD) || (w_next_state == ST_CPU_WR);
  assign w_vga_issue = (w_next_state == ST_VGA_RD);
  assign w_accept    = cpu_req && !r_pending;
  assign w_tag_in    = owner_of(w_next_state);

  // Count consecutive cycles a pending CPU op loses to the display fetch.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!r_pending || w_cpu_issue) begin
      w_starve_nxt = 4'd0;
    end else if (w_vga_issue) begin
      w_starve_nxt = (r_starve_cnt == STARVE_LIM) ? STARVE_LIM : r_starve_cnt + 4'd1;
    end else begin
      w_starve_nxt = r_starve_cnt;
    end
  end

  // CPU holding register: accept when empty, empty again once issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending     <= 1'b0;
      r_p_we        <= 1'b0;
      r_p_addr      <= {ADDR_W{1'b0}};
      r_p_wdata     <= {DATA_W{1'b0}};
      r_starve_cnt  <= 4'd0;
      r_starve_flag <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      if (w_override) begin
        r_starve_flag <= 1'b1;
      end else begin
        r_starve_flag <= r_starve_flag;
      end
      if (w_cpu_issue) begin
        r_pending <= 1'b0;
      end else if (w_accept) begin
        r_pending <= 1'b1;
        r_p_we    <= cpu_we;
        r_p_addr  <= cpu_addr;
        r_p_wdata <= cpu_wdata;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

  // Register the chosen operation onto the memory port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
    end else begin
      r_state  <= w_next_state;
      r_mem_en <= (w_next_state != ST_IDLE);
      r_mem_we <= (w_next_state == ST_CPU_WR);
      case (w_next_state)
        ST_VGA_RD: begin
          r_mem_addr  <= vga_addr;
          r_mem_wdata <= {DATA_W{1'b0}};
        end
        ST_CPU_RD: begin
          r_mem_addr  <= r_p_addr;
          r_mem_wdata <= {DATA_W{1'b0}};
        end
        ST_CPU_WR: begin
          r_mem_addr  <= r_p_addr;
          r_mem_wdata <= r_p_wdata;
        end
        default: begin
          r_mem_addr  <= {ADDR_W{1'b0}};
          r_mem_wdata <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

  vram_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // Route returning read data to its owner; writes ack the cycle after issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vga_data  <= {DATA_W{1'b0}};
      r_vga_valid <= 1'b0;
      r_cpu_rdata <= {DATA_W{1'b0}};
      r_cpu_ack   <= 1'b0;
    end else begin
      r_vga_valid <= (w_tag_out == OWN_VGA);
      r_cpu_ack   <= (w_tag_out == OWN_CPU) || (r_state == ST_CPU_WR);
      if (w_tag_out == OWN_VGA) begin
        r_vga_data <= mem_rdata;
      end else begin
        r_vga_data <= r_vga_data;
      end
      if (w_tag_out == OWN_CPU) begin
        r_cpu_rdata <= mem_rdata;
      end else begin
        r_cpu_rdata <= r_cpu_rdata;
      end
    end
  end

  assign vga_gnt     = w_vga_issue;
  assign cpu_ready   = !r_pending;
  assign vga_data    = r_vga_data;
  assign vga_valid   = r_vga_valid;
  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_ack     = r_cpu_ack;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign starve_flag = r_starve_flag;

endmodule
